// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv
//
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// It sits in EX beside the combinational ALU. MULT/MULTU/DIV/DIVU take one
// bit per cycle. MTHI/MTLO write HI/LO in a single cycle. MFHI/MFLO are plain
// combinational reads.
//
// Operation sequence: IDLE -> RUN (DATA_WIDTH cycles) -> FIX (1 cycle) -> IDLE.
// A divide by zero skips RUN and goes straight from IDLE to FIX.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset; aborts any operation
//   i_start      issue strobe; i_mode/i_A/i_B are sampled with it (IDLE only)
//   i_mode       MIPS funct field selecting the operation
//   i_A          rs operand (dividend / multiplicand / MTxx source)
//   i_B          rt operand (divisor / multiplier)
//   o_result     HI when i_mode is MFHI, LO when MFLO, otherwise zero
//   o_hi, o_lo   architectural HI and LO registers
//   o_busy       an operation is in flight; i_start is ignored while high
//   o_done       one-cycle pulse after HI/LO are written by MULT/DIV
//   o_div_zero   one-cycle pulse with o_done when that divide had i_B == 0
// ---------------------------------------------------------------------------
module alu_muldiv #(
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [MODE_WIDTH-1:0] i_mode,
    input  logic [DATA_WIDTH-1:0] i_A,
    input  logic [DATA_WIDTH-1:0] i_B,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_div_zero
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [MODE_WIDTH-1:0] F_MFHI  = MODE_WIDTH'(6'b010000);
    localparam logic [MODE_WIDTH-1:0] F_MTHI  = MODE_WIDTH'(6'b010001);
    localparam logic [MODE_WIDTH-1:0] F_MFLO  = MODE_WIDTH'(6'b010010);
    localparam logic [MODE_WIDTH-1:0] F_MTLO  = MODE_WIDTH'(6'b010011);
    localparam logic [MODE_WIDTH-1:0] F_MULT  = MODE_WIDTH'(6'b011000);
    localparam logic [MODE_WIDTH-1:0] F_MULTU = MODE_WIDTH'(6'b011001);
    localparam logic [MODE_WIDTH-1:0] F_DIV   = MODE_WIDTH'(6'b011010);
    localparam logic [MODE_WIDTH-1:0] F_DIVU  = MODE_WIDTH'(6'b011011);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t           state;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;

    // Both algorithms share one 2W-bit work register.
    // Multiply: upper half is the running partial sum and the lower half
    //   holds the multiplier; the register shifts right each cycle.
    // Divide: upper half is the partial remainder and the lower half holds
    //   the dividend. Quotient bits shift in at the bottom as the dividend
    //   bits shift out of the top.
    logic [2*W-1:0]   work;
    logic [W-1:0]     mag_a;
    logic [W-1:0]     mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             is_div;
    logic             dz_pending;
    logic [CNT_W-1:0] count;

    logic             op_signed;
    logic             in_sign_a;
    logic             in_sign_b;
    logic [W-1:0]     in_mag_a;
    logic [W-1:0]     in_mag_b;

    logic [W-1:0]     mul_addend;
    logic [W:0]       mul_sum;
    logic [2*W-1:0]   mul_next;

    logic [W:0]       div_trial;
    logic [W:0]       div_diff;
    logic             div_ge;
    logic [2*W-1:0]   div_next;

    logic             neg_res;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quot_fix;
    logic [W-1:0]     rem_fix;
    logic [W-1:0]     dz_hi;

    // Operand conditioning at issue. Signed ops work on magnitudes and
    // remember the operand signs for the fix-up step. Unsigned ops pass the
    // operands through with both signs forced to zero.
    always_comb begin
        op_signed = (i_mode == F_MULT) || (i_mode == F_DIV);
        in_sign_a = op_signed & i_A[W-1];
        in_sign_b = op_signed & i_B[W-1];
        in_mag_a  = in_sign_a ? -i_A : i_A;
        in_mag_b  = in_sign_b ? -i_B : i_B;
    end

    // One shift-add multiply step. The carry out of the add becomes the new
    // top bit as the whole register shifts right.
    always_comb begin
        mul_addend = work[0] ? mag_a : '0;
        mul_sum    = {1'b0, work[2*W-1:W]} + {1'b0, mul_addend};
        mul_next   = {mul_sum, work[W-1:1]};
    end

    // One restoring-divide step. The trial value is the remainder shifted
    // left with the next dividend bit appended. The divisor is subtracted
    // only when it fits, and that outcome is the next quotient bit.
    always_comb begin
        div_trial = work[2*W-1:W-1];
        div_diff  = div_trial - {1'b0, mag_b};
        div_ge    = (div_trial >= {1'b0, mag_b});
        if (div_ge) begin
            div_next = {div_diff[W-1:0], work[W-2:0], 1'b1};
        end else begin
            div_next = {div_trial[W-1:0], work[W-2:0], 1'b0};
        end
    end

    // Sign restoration applied in FIX. The product and the quotient are
    // negative when the operand signs differ. The remainder follows the
    // dividend. Negating the magnitude 100..0 gives 100..0 again, so the
    // most-negative / -1 case wraps with no special handling. On a divide by
    // zero HI returns the original dividend, which is rebuilt from its
    // magnitude and sign.
    always_comb begin
        neg_res  = sign_a ^ sign_b;
        prod_fix = neg_res ? -work : work;
        quot_fix = neg_res ? -work[W-1:0] : work[W-1:0];
        rem_fix  = sign_a ? -work[2*W-1:W] : work[2*W-1:W];
        dz_hi    = sign_a ? -mag_a : mag_a;
    end

    // Control, datapath and architectural registers live in this one block.
    // A reset at any point clears everything. An aborted operation therefore
    // never reaches FIX and never writes HI/LO. o_done and o_div_zero
    // default low each cycle, which makes them single-cycle pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            work       <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            is_div     <= 1'b0;
            dz_pending <= 1'b0;
            count      <= '0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        case (i_mode)
                            F_MTHI: hi_q <= i_A;
                            F_MTLO: lo_q <= i_A;
                            F_MULT, F_MULTU: begin
                                mag_a      <= in_mag_a;
                                mag_b      <= in_mag_b;
                                sign_a     <= in_sign_a;
                                sign_b     <= in_sign_b;
                                is_div     <= 1'b0;
                                dz_pending <= 1'b0;
                                work       <= {{W{1'b0}}, in_mag_b};
                                count      <= CNT_W'(W - 1);
                                busy_q     <= 1'b1;
                                state      <= S_RUN;
                            end
                            F_DIV, F_DIVU: begin
                                mag_a      <= in_mag_a;
                                mag_b      <= in_mag_b;
                                sign_a     <= in_sign_a;
                                sign_b     <= in_sign_b;
                                is_div     <= 1'b1;
                                work       <= {{W{1'b0}}, in_mag_a};
                                count      <= CNT_W'(W - 1);
                                busy_q     <= 1'b1;
                                if (i_B == '0) begin
                                    dz_pending <= 1'b1;
                                    state      <= S_FIX;
                                end else begin
                                    dz_pending <= 1'b0;
                                    state      <= S_RUN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    work  <= is_div ? div_next : mul_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (dz_pending) begin
                        hi_q <= dz_hi;
                        lo_q <= '1;
                    end else if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*W-1:W];
                        lo_q <= prod_fix[W-1:0];
                    end
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    div_zero_q <= dz_pending;
                    dz_pending <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // MFHI/MFLO read the registers directly. While an operation is in flight
    // they return the values from before that operation.
    always_comb begin
        if (i_mode == F_MFHI) begin
            o_result = hi_q;
        end else if (i_mode == F_MFLO) begin
            o_result = lo_q;
        end else begin
            o_result = '0;
        end
    end

    assign o_hi       = hi_q;
    assign o_lo       = lo_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv
//
// Bench for alu_muldiv at DATA_WIDTH=8. It keeps a reference model that
// computes each result with plain integer arithmetic and tracks only the
// number of cycles left before commit. Every cycle the DUT outputs are
// compared against that model. Directed operations also pin the model with
// hand-computed constants. A randomized stream follows.
// ---------------------------------------------------------------------------
module tb_alu_muldiv;

    localparam int W = 8;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clock;
    logic         reset;
    logic         start;
    logic [5:0]   mode;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         divZero;

    int nVectors = 0;
    int nMiss    = 0;

    logic [W-1:0] mHi;
    logic [W-1:0] mLo;
    logic         mBusy;
    logic         mDone;
    logic         mDz;
    int           mLeft;
    logic [W-1:0] pHi;
    logic [W-1:0] pLo;
    logic         pDz;

    alu_muldiv #(
        .DATA_WIDTH(W),
        .MODE_WIDTH(6)
    ) dut (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_start   (start),
        .i_mode    (mode),
        .i_A       (aIn),
        .i_B       (bIn),
        .o_result  (result),
        .o_hi      (hi),
        .o_lo      (lo),
        .o_busy    (busy),
        .o_done    (done),
        .o_div_zero(divZero)
    );

    // Free-running clock with a 10-time-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference result of one MULT/DIV-class operation, packed as {dz, hi, lo}.
    function automatic logic [16:0] refOp(input logic [5:0] m, input logic [7:0] a, input logic [7:0] b);
        int          sa;
        int          sb;
        int          p;
        int          q;
        int          r;
        int unsigned ua;
        int unsigned ub;
        int unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (m)
            F_MULT: begin
                p = sa * sb;
                return {1'b0, p[15:0]};
            end
            F_MULTU: begin
                up = ua * ub;
                return {1'b0, up[15:0]};
            end
            F_DIV: begin
                if (b == 8'h00) return {1'b1, a, 8'hFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[7:0], q[7:0]};
            end
            F_DIVU: begin
                if (b == 8'h00) return {1'b1, a, 8'hFF};
                up = ua / ub;
                q  = int'(ua % ub);
                return {1'b0, q[7:0], up[7:0]};
            end
            default: return '0;
        endcase
    endfunction

    function automatic logic isArith(input logic [5:0] m);
        return (m == F_MULT) || (m == F_MULTU) || (m == F_DIV) || (m == F_DIVU);
    endfunction

    // Behavioural model. An accepted arithmetic op sets a countdown of
    // W+1 cycles, or 1 for a divide by zero. When the countdown expires the
    // precomputed result lands in HI/LO and done pulses. Issues are accepted
    // only while nothing is pending.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mHi   <= '0;
            mLo   <= '0;
            mBusy <= 1'b0;
            mDone <= 1'b0;
            mDz   <= 1'b0;
            mLeft <= 0;
            pHi   <= '0;
            pLo   <= '0;
            pDz   <= 1'b0;
        end else begin
            mDone <= 1'b0;
            mDz   <= 1'b0;
            if (mLeft != 0) begin
                mLeft <= mLeft - 1;
                if (mLeft == 1) begin
                    mHi   <= pHi;
                    mLo   <= pLo;
                    mBusy <= 1'b0;
                    mDone <= 1'b1;
                    mDz   <= pDz;
                end
            end else if (start) begin
                if (mode == F_MTHI) mHi <= aIn;
                if (mode == F_MTLO) mLo <= aIn;
                if (isArith(mode)) begin
                    mBusy <= 1'b1;
                    {pDz, pHi, pLo} <= refOp(mode, aIn, bIn);
                    mLeft <= (((mode == F_DIV) || (mode == F_DIVU)) && (bIn == 8'h00)) ? 1 : W + 1;
                end
            end
        end
    end

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        logic [W-1:0] expResult;
        expResult = (mode == F_MFHI) ? mHi : (mode == F_MFLO) ? mLo : '0;
        compareVal("busy", busy, mBusy);
        compareVal("done", done, mDone);
        compareVal("div_zero", divZero, mDz);
        compareVal("hi", hi, mHi);
        compareVal("lo", lo, mLo);
        compareVal("result", result, expResult);
    endtask

    // Drive one cycle of inputs. The DUT and the model consume them at the
    // next rising edge, and the outputs are checked at the falling edge after.
    task automatic applyStimulus(input logic s, input logic [5:0] m, input logic [7:0] a, input logic [7:0] b);
        start = s;
        mode  = m;
        aIn   = a;
        bIn   = b;
        @(negedge clock);
        checkOutput();
    endtask

    // Issue one op and count the cycles o_busy stays high, bounded by a guard.
    task automatic runOp(input logic [5:0] m, input logic [7:0] a, input logic [7:0] b, output int busyCycles);
        int guard;
        applyStimulus(1'b1, m, a, b);
        busyCycles = 0;
        guard      = 0;
        while (busy && guard < 40) begin
            busyCycles++;
            guard++;
            applyStimulus(1'b0, m, a, b);
        end
    endtask

    initial begin
        int          bc;
        int          guard;
        logic [5:0]  modeTable [10];
        logic        rs;
        logic [5:0]  rm;
        logic [7:0]  ra;
        logic [7:0]  rb;

        modeTable = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b000000, 6'b111111};

        start = 1'b0;
        mode  = 6'b0;
        aIn   = '0;
        bIn   = '0;
        reset = 1'b1;

        @(negedge clock);
        checkOutput();
        compareVal("reset_busy", busy, 1'b0);
        compareVal("reset_hi", hi, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] MULTU 200*3");
        runOp(F_MULTU, 8'd200, 8'd3, bc);
        compareVal("multu_busy_cycles", bc, 9);
        compareVal("multu_done", done, 1'b1);
        compareVal("multu_hi", hi, 8'h02);
        compareVal("multu_lo", lo, 8'h58);

        $display("[TB] MULT -3*5 issued back-to-back on done");
        runOp(F_MULT, 8'hFD, 8'h05, bc);
        compareVal("mult_hi", hi, 8'hFF);
        compareVal("mult_lo", lo, 8'hF1);
        applyStimulus(1'b0, F_MFLO, 8'h00, 8'h00);
        compareVal("mflo_result", result, 8'hF1);

        $display("[TB] DIV / DIVU 0xF9 by 2");
        runOp(F_DIV, 8'hF9, 8'h02, bc);
        compareVal("div_lo", lo, 8'hFD);
        compareVal("div_hi", hi, 8'hFF);
        runOp(F_DIVU, 8'hF9, 8'h02, bc);
        compareVal("divu_lo", lo, 8'h7C);
        compareVal("divu_hi", hi, 8'h01);

        $display("[TB] DIVU by zero");
        runOp(F_DIVU, 8'h64, 8'h00, bc);
        compareVal("dz_busy_cycles", bc, 1);
        compareVal("dz_done", done, 1'b1);
        compareVal("dz_flag", divZero, 1'b1);
        compareVal("dz_hi", hi, 8'h64);
        compareVal("dz_lo", lo, 8'hFF);
        applyStimulus(1'b0, F_MFHI, 8'h00, 8'h00);
        compareVal("dz_flag_clear", divZero, 1'b0);

        $display("[TB] DIV overflow with ignored second issue");
        applyStimulus(1'b1, F_DIV, 8'h80, 8'hFF);
        applyStimulus(1'b1, F_MULTU, 8'h11, 8'h22);
        guard = 0;
        while (busy && guard < 40) begin
            guard++;
            applyStimulus(1'b0, F_MFHI, 8'h00, 8'h00);
        end
        compareVal("ovf_lo", lo, 8'h80);
        compareVal("ovf_hi", hi, 8'h00);
        applyStimulus(1'b0, F_MFHI, 8'h00, 8'h00);
        compareVal("ovf_no_second_op", busy, 1'b0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, F_MULTU, 8'hFF, 8'hFF);
        applyStimulus(1'b0, F_MULTU, 8'hFF, 8'hFF);
        applyStimulus(1'b0, F_MULTU, 8'hFF, 8'hFF);
        applyStimulus(1'b0, F_MULTU, 8'hFF, 8'hFF);
        reset = 1'b1;
        #1;
        compareVal("abort_busy", busy, 1'b0);
        compareVal("abort_hi", hi, 8'h00);
        compareVal("abort_lo", lo, 8'h00);
        @(negedge clock);
        checkOutput();
        reset = 1'b0;
        applyStimulus(1'b1, F_MTHI, 8'h5A, 8'h00);
        compareVal("mthi_hi", hi, 8'h5A);
        compareVal("mthi_no_done", done, 1'b0);
        compareVal("mthi_no_busy", busy, 1'b0);
        applyStimulus(1'b0, F_MFHI, 8'h00, 8'h00);
        compareVal("mfhi_result", result, 8'h5A);

        $display("[TB] randomized stream");
        for (int i = 0; i < 1200; i++) begin
            rs = ($urandom_range(0, 2) == 0);
            rm = modeTable[$urandom_range(0, 9)];
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus(rs, rm, ra, rb);
        end
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, F_MFLO, 8'h00, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
